// File: rtl/refcount_mp_if.sv
// ---------------------------------------------------------------------------
// refcount_mp_if
//   Groups the rename-side alloc lanes, the commit-side dealloc lanes and the
//   freed-PR / stall outputs of the physical-register reference counter.
//
//   Signals (lane k of a packed PR index bus sits at [k*PR_W +: PR_W]):
//     i_alloc_req          ALLOC_PORTS          alloc lane valid
//     i_alloc_ismv         ALLOC_PORTS          1: eliminated move, 0: fresh PR
//     i_alloc_prIdx        ALLOC_PORTS*PR_W     destination PR per alloc lane
//     i_dealloc_req        DEALLOC_PORTS        old-PR release valid
//     i_dealloc_prIdx      DEALLOC_PORTS*PR_W   released PR per dealloc lane
//     o_real_dealloc_req   DEALLOC_PORTS        PR truly freed
//     o_real_dealloc_prIdx DEALLOC_PORTS*PR_W   freed PR per lane
//     o_mv_stall           1                    rename must not issue ismv
//
//   Modports:
//     master - rename/commit side (drives requests, observes results)
//     slave  - the reference counter itself
// ---------------------------------------------------------------------------
interface refcount_mp_if #(
    parameter int NUM_PR        = 64,
    parameter int ALLOC_PORTS   = 4,
    parameter int DEALLOC_PORTS = 4
);
    localparam int PR_W = $clog2(NUM_PR);

    logic [ALLOC_PORTS-1:0]        i_alloc_req;
    logic [ALLOC_PORTS-1:0]        i_alloc_ismv;
    logic [ALLOC_PORTS*PR_W-1:0]   i_alloc_prIdx;
    logic [DEALLOC_PORTS-1:0]      i_dealloc_req;
    logic [DEALLOC_PORTS*PR_W-1:0] i_dealloc_prIdx;
    logic [DEALLOC_PORTS-1:0]      o_real_dealloc_req;
    logic [DEALLOC_PORTS*PR_W-1:0] o_real_dealloc_prIdx;
    logic                          o_mv_stall;

    modport master (
        output i_alloc_req, i_alloc_ismv, i_alloc_prIdx,
        output i_dealloc_req, i_dealloc_prIdx,
        input  o_real_dealloc_req, o_real_dealloc_prIdx, o_mv_stall
    );

    modport slave (
        input  i_alloc_req, i_alloc_ismv, i_alloc_prIdx,
        input  i_dealloc_req, i_dealloc_prIdx,
        output o_real_dealloc_req, o_real_dealloc_prIdx, o_mv_stall
    );
endinterface

// File: rtl/refcount_mp.sv
// ---------------------------------------------------------------------------
// refcount_mp
//   Multi-port physical-register reference counter for rename-stage move
//   elimination. Each PR carries a count of extra sharers. Eliminated moves
//   add a sharer, fresh allocations clear the count, and commit-side
//   releases either consume a sharer or, when none remain, truly free the PR
//   towards the freelist.
//
//   Ports:
//     clk   in   clock
//     rst   in   synchronous active-high reset
//     bus   refcount_mp_if.slave (alloc lanes, dealloc lanes, freed PRs,
//           move-elimination stall)
//     o_err out  sticky error flag (only when REFCOUNT_ERR_EN is defined)
//
//   Build option:
//     REFCOUNT_ERR_EN - adds o_err, set the cycle after a saturating
//                       increment or a same-cycle double free; cleared only
//                       by rst. Without it those cases silently saturate or
//                       drop the duplicate free.
// ---------------------------------------------------------------------------
module refcount_mp #(
    parameter int NUM_PR        = 64,
    parameter int ALLOC_PORTS   = 4,
    parameter int DEALLOC_PORTS = 4,
    parameter int CNT_W         = 3
) (
    input  logic               clk,
    input  logic               rst,
`ifdef REFCOUNT_ERR_EN
    refcount_mp_if.slave       bus,
    output logic               o_err
`else
    refcount_mp_if.slave       bus
`endif
);
    localparam int PR_W = $clog2(NUM_PR);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // Counts at or above this value could overflow if every alloc lane
    // carried an eliminated move to the same PR next cycle.
    localparam int STALL_TH = (2 ** CNT_W - 1) - ALLOC_PORTS + 1;

    logic [CNT_W-1:0]              cnt_q [NUM_PR];
    logic [CNT_W-1:0]              cnt_d [NUM_PR];
    logic [DEALLOC_PORTS-1:0]      real_req_q;
    logic [DEALLOC_PORTS-1:0]      real_req_d;
    logic [DEALLOC_PORTS*PR_W-1:0] real_idx_q;
    logic [DEALLOC_PORTS*PR_W-1:0] real_idx_d;
    logic                          stall_q;
    logic                          stall_d;
    logic                          ovf_s;
    logic                          dbl_s;
    logic [NUM_PR-1:0]             freed_s;

    // Single combinational pass: fresh clears, then shared increments, then
    // dealloc lanes in ascending order against the running effective count.
    always_comb begin
        logic [PR_W-1:0]  pr_v;
        logic [CNT_W-1:0] cur_v;
        logic             inc_v;
        logic             at_max_v;
        logic             dec_v;
        logic             hit_zero_v;
        logic             free_v;

        cnt_d      = cnt_q;
        ovf_s      = 1'b0;
        dbl_s      = 1'b0;
        freed_s    = {NUM_PR{1'b0}};
        real_req_d = {DEALLOC_PORTS{1'b0}};
        real_idx_d = {(DEALLOC_PORTS*PR_W){1'b0}};
        stall_d    = 1'b0;
        pr_v       = {PR_W{1'b0}};
        cur_v      = {CNT_W{1'b0}};
        inc_v      = 1'b0;
        at_max_v   = 1'b0;
        dec_v      = 1'b0;
        hit_zero_v = 1'b0;
        free_v     = 1'b0;

        // Fresh owners restart the sharer count before any same-cycle sharing.
        for (int a = 0; a < ALLOC_PORTS; a++) begin
            pr_v        = bus.i_alloc_prIdx[a*PR_W +: PR_W];
            cnt_d[pr_v] = (bus.i_alloc_req[a] && !bus.i_alloc_ismv[a])
                          ? {CNT_W{1'b0}} : cnt_d[pr_v];
        end

        // Eliminated moves add a sharer, saturating at CNT_MAX.
        for (int a = 0; a < ALLOC_PORTS; a++) begin
            pr_v        = bus.i_alloc_prIdx[a*PR_W +: PR_W];
            inc_v       = bus.i_alloc_req[a] && bus.i_alloc_ismv[a];
            at_max_v    = (cnt_d[pr_v] == CNT_MAX);
            ovf_s       = ovf_s | (inc_v && at_max_v);
            cnt_d[pr_v] = cnt_d[pr_v]
                          + {{(CNT_W-1){1'b0}}, (inc_v && !at_max_v)};
        end

        // Releases consume a sharer if one exists, otherwise free the PR;
        // only the lowest lane may free a given PR within one cycle.
        for (int k = 0; k < DEALLOC_PORTS; k++) begin
            pr_v          = bus.i_dealloc_prIdx[k*PR_W +: PR_W];
            cur_v         = cnt_d[pr_v];
            dec_v         = bus.i_dealloc_req[k] && (cur_v != {CNT_W{1'b0}});
            hit_zero_v    = bus.i_dealloc_req[k] && (cur_v == {CNT_W{1'b0}});
            free_v        = hit_zero_v && !freed_s[pr_v];
            dbl_s         = dbl_s | (hit_zero_v && freed_s[pr_v]);
            cnt_d[pr_v]   = cur_v - {{(CNT_W-1){1'b0}}, dec_v};
            freed_s[pr_v] = freed_s[pr_v] | free_v;
            real_req_d[k] = free_v;
            real_idx_d[k*PR_W +: PR_W] = free_v ? pr_v : {PR_W{1'b0}};
        end

        // Stall looks at the post-update counts so the next cycle is safe.
        for (int i = 0; i < NUM_PR; i++) begin
            stall_d = stall_d | (int'(cnt_d[i]) >= STALL_TH);
        end
    end

    // State and output registers; reset discards any same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '{default: {CNT_W{1'b0}}};
            real_req_q <= {DEALLOC_PORTS{1'b0}};
            real_idx_q <= {(DEALLOC_PORTS*PR_W){1'b0}};
            stall_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            real_req_q <= real_req_d;
            real_idx_q <= real_idx_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.o_real_dealloc_req   = real_req_q;
    assign bus.o_real_dealloc_prIdx = real_idx_q;
    assign bus.o_mv_stall           = stall_q;

`ifdef REFCOUNT_ERR_EN
    logic err_q;
    logic err_d;

    // Error flag accumulates overflow and double-free events until reset.
    always_comb begin
        err_d = err_q | ovf_s | dbl_s;
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    // Without the error option the event flags have no consumer.
    logic unused_err_s;
    assign unused_err_s = ovf_s | dbl_s;
`endif

endmodule
